// File: rtl/reg_names.sv
// Shared register-file types: ABI register names, widths and the dump FSM state encoding.
package reg_names;

  localparam int DATA_WIDTH = 32;
  localparam int REG_COUNT  = 32;
  localparam int IDX_WIDTH  = 5;

  // RISC-V ABI names in architectural index order.
  typedef enum logic [IDX_WIDTH-1:0] {
    zero = 5'd0,  ra  = 5'd1,  sp  = 5'd2,  gp  = 5'd3,
    tp   = 5'd4,  t0  = 5'd5,  t1  = 5'd6,  t2  = 5'd7,
    s0   = 5'd8,  s1  = 5'd9,  a0  = 5'd10, a1  = 5'd11,
    a2   = 5'd12, a3  = 5'd13, a4  = 5'd14, a5  = 5'd15,
    a6   = 5'd16, a7  = 5'd17, s2  = 5'd18, s3  = 5'd19,
    s4   = 5'd20, s5  = 5'd21, s6  = 5'd22, s7  = 5'd23,
    s8   = 5'd24, s9  = 5'd25, s10 = 5'd26, s11 = 5'd27,
    t3   = 5'd28, t4  = 5'd29, t5  = 5'd30, t6  = 5'd31
  } regName_t;

  // Final register presented by a dump.
  localparam regName_t DUMP_LAST = t6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dumpState_t;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Dump sequencer: walks every register index once over a valid/ready stream
// and tells the register file which index to capture into the beat register.
//
// state | meaning
// IDLE  | waiting for dump_start
// SEND  | beat at dump_idx is valid, waiting for dump_ready
// DONE  | last beat accepted, dump_done pulses for this one cycle
import reg_names::*;

module reg_dump_ctrl (
  input  logic     clk,
  input  logic     rst,
  input  logic     dump_start,
  input  logic     dump_ready,
  output logic     dump_valid,
  output regName_t dump_idx,
  output logic     dump_busy,
  output logic     dump_done,
  output logic     load,
  output regName_t load_idx
);

  dumpState_t state;

  // Load strobe fires on the edge at which a new index becomes current, so
  // the captured data lines up with dump_idx with no bubble.
  always_comb begin
    load     = 1'b0;
    load_idx = zero;
    if (state == IDLE && dump_start) begin
      load     = 1'b1;
      load_idx = zero;
    end else if (state == SEND && dump_valid && dump_ready && dump_idx != DUMP_LAST) begin
      load     = 1'b1;
      load_idx = regName_t'(dump_idx + 5'd1);
    end
  end

  // Sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dump_valid <= 1'b0;
      dump_idx   <= zero;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dump_done <= 1'b0;
          if (dump_start) begin
            state      <= SEND;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
            dump_idx   <= zero;
          end
        end
        SEND: begin
          if (dump_valid && dump_ready) begin
            if (dump_idx == DUMP_LAST) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_idx <= regName_t'(dump_idx + 5'd1);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_done <= 1'b0;
          dump_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          dump_valid <= 1'b0;
          dump_busy  <= 1'b0;
          dump_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with write-through bypass, hardwired x0,
// and a streaming dump port that snapshots each register as it is presented.
import reg_names::*;

module reg_file #(
  parameter int                    DATA_WIDTH = reg_names::DATA_WIDTH,
  parameter int                    REG_COUNT  = reg_names::REG_COUNT,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0000_0FFC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  regName_t              rs1,
  input  regName_t              rs2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  input  logic                  wr_en,
  input  regName_t              rd,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  dump_start,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output regName_t              dump_idx,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_busy,
  output logic                  dump_done
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic                  load;
  regName_t              load_idx;

  // Value a reader should see this cycle: x0 reads zero, a pending write wins.
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input regName_t              addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  w_en,
    input regName_t              w_addr,
    input logic [DATA_WIDTH-1:0] w_data
  );
    if (addr == zero)                return '0;
    if (w_en && w_addr == addr)      return w_data;
    return stored;
  endfunction

  // Register array; sp comes out of reset pointing at the top of the stack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= (i == int'(sp)) ? SP_INIT : '0;
      end
    end else if (wr_en && rd != zero) begin
      regs[rd] <= wr_data;
    end
  end

  // Combinational read ports with same-cycle write bypass.
  always_comb begin
    rd_data1 = fwd(rs1, regs[rs1], wr_en, rd, wr_data);
    rd_data2 = fwd(rs2, regs[rs2], wr_en, rd, wr_data);
  end

  // Beat register: captured only when a new index is loaded, so a stalled
  // beat stays frozen even if its register is overwritten meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_data <= '0;
    end else if (load) begin
      dump_data <= fwd(load_idx, regs[load_idx], wr_en, rd, wr_data);
    end
  end

  reg_dump_ctrl u_dump_ctrl (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .load       (load),
    .load_idx   (load_idx)
  );

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32 (reg_names::DATA_WIDTH): register and port data width.
REQ-002 SHALL have parameter REG_COUNT, default 32 (reg_names::REG_COUNT): number of architectural registers.
REQ-003 SHALL have parameter SP_INIT, default 32'h0000_0FFC: reset value of sp.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port rs1  input  5  read port 1 address, type regName_t.
REQ-008 SHALL have port rs2  input  5  read port 2 address, type regName_t.
REQ-009 SHALL have port rd_data1  output  DATA_WIDTH  read port 1 data.
REQ-010 SHALL have port rd_data2  output  DATA_WIDTH  read port 2 data.
REQ-011 SHALL have port wr_en  input  1  write enable.
REQ-012 SHALL have port rd  input  5  write address, type regName_t.
REQ-013 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-014 SHALL have port dump_start  input  1  request a full register dump.
REQ-015 SHALL have port dump_valid  output  1  dump beat valid.
REQ-016 SHALL have port dump_ready  input  1  dump beat accepted by the sink.
REQ-017 SHALL have port dump_idx  output  5  register index of the current beat, type regName_t.
REQ-018 SHALL have port dump_data  output  DATA_WIDTH  register value of the current beat.
REQ-019 SHALL have port dump_busy  output  1  high while the dump FSM is not IDLE.
REQ-020 SHALL have port dump_done  output  1  one-cycle pulse after the last beat.

Function
REQ-021 SHALL perform reads combinationally: rd_dataN equals reg[rsN] in the same cycle.
REQ-022 SHALL return 0 on any read of zero (x0); writes to zero SHALL be ignored.
REQ-023 SHALL perform writes on the clk rising edge when wr_en=1 and rd!=zero.
REQ-024 SHALL bypass writes: when wr_en=1, rd==rsN and rd!=zero, rd_dataN SHALL equal wr_data in the same cycle.
REQ-025 SHALL implement a dump FSM with states IDLE, SEND and DONE.
REQ-026 SHALL move from IDLE to SEND when dump_start=1; dump_valid SHALL go high on the next cycle with dump_idx=0.
REQ-027 SHALL ignore dump_start outside IDLE.
REQ-028 SHALL capture dump_data in a register when an index is loaded, using the bypassed value of that register, including a same-cycle write.
REQ-029 SHALL hold dump_idx and dump_data stable while dump_valid=1 and dump_ready=0; a later write to that index SHALL NOT alter the held beat.
REQ-030 SHALL, on handshake (valid&&ready) with dump_idx<31, advance dump_idx by 1 and load its data on the next cycle, with no bubble.
REQ-031 SHALL, on handshake with dump_idx=31, go to DONE; dump_valid=0 and dump_done=1 for one cycle, then return to IDLE.
REQ-032 SHALL assert dump_busy in SEND and DONE.
REQ-033 SHALL keep read and write ports fully functional during a dump.

Reset
REQ-034 SHALL, while rst=1, clear all registers to 0 except sp=SP_INIT.
REQ-035 SHALL, while rst=1, force the FSM to IDLE with dump_valid=0, dump_done=0, dump_busy=0, dump_idx=0 and dump_data=0.
REQ-036 SHALL, when rst asserts mid-dump, abort immediately without a dump_done pulse.

Structure
REQ-037 SHALL import regName_t, DATA_WIDTH and REG_COUNT from package reg_names.
REQ-038 SHALL define the dump FSM state enum dumpState_t in reg_names.
REQ-039 SHALL implement the dump FSM as sub-module reg_dump_ctrl, which issues the index and load strobes.

Verification
REQ-040 SHALL verify: reset, then read sp and a0 -> 32'h0000_0FFC and 0.
REQ-041 SHALL verify: write zero=32'hDEAD_BEEF, then read zero -> 0.
REQ-042 SHALL verify: wr_en=1, rd=a0, wr_data=32'h1234_5678 with rs1=a0 in the same cycle -> rd_data1=32'h1234_5678 that cycle.
REQ-043 SHALL verify: registers t0..t6 preloaded to their indices, dump_start, dump_ready=1 -> 32 consecutive beats idx 0..31 with data equal to contents, then dump_done pulses once.
REQ-044 SHALL verify: dump_ready=0 at idx 5 for 4 cycles while writing t0=32'hAAAA_AAAA -> beat holds the old t0 value, and idx 5 transfers once ready=1.
REQ-045 SHALL verify: rst pulsed at idx 12 mid-dump -> dump_valid=0 immediately, no dump_done, and all registers read reset values.
